// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types and frame geometry for the rx packer
package rx_pkg;

  localparam int FRAME_W = 129;
  localparam int KEY_W   = 128;
  localparam int BEATS   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_idle_timer.sv
// rtl/rx_idle_timer.sv - counts consecutive idle cycles and flags the cycle the limit is reached
module rx_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] cnt;

  // expired marks the idle cycle whose edge would bring the count to TIMEOUT
  assign expired = run && !clear && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= 8'd0;
    end else if (clear || expired) begin
      cnt <= 8'd0;
    end else if (run) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/rx_packer.sv
// rtl/rx_packer.sv - packs four 32-bit beats plus a mode flag into a 129-bit frame
module rx_packer
  import rx_pkg::*;
#(
  parameter int BEAT_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               wr_en,
  input  logic [BEAT_W-1:0]  wr_data,
  input  logic               wr_flag,
  input  logic               abort,
  output logic               wr_ready,
  output logic               read,
  output logic [FRAME_W-1:0] data_in,
  output logic               timeout_err
);

  rx_state_t                     state, state_nxt;
  logic [1:0]                    cnt, cnt_nxt;
  logic                          accept;
  logic                          idle_run;
  logic                          idle_clear;
  logic                          idle_expired;
  logic [(BEATS-1)*BEAT_W-1:0]   partial;

  assign wr_ready = (state != EMIT);
  assign read     = (state == EMIT);

  // abort discards a beat offered in the same cycle
  assign accept     = wr_en && wr_ready && !abort;
  assign idle_run   = (state == COLLECT) && !accept && !abort;
  assign idle_clear = (state != COLLECT) || accept || abort;

  rx_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (idle_clear),
    .run     (idle_run),
    .expired (idle_expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = COLLECT;
          cnt_nxt   = 2'd1;
        end
      end
      COLLECT: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end else if (accept) begin
          if (cnt == 2'd3) begin
            state_nxt = EMIT;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt = cnt + 2'd1;
          end
        end else if (idle_expired) begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end
      end
      EMIT: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

  // data_in only moves on the edge that accepts the final beat
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      partial <= '0;
      data_in <= '0;
    end else if (accept) begin
      if (cnt == 2'd3) begin
        data_in <= {wr_flag, wr_data, partial};
      end else begin
        partial[cnt*BEAT_W +: BEAT_W] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= idle_expired;
    end
  end

endmodule

// File: tb/tb_rx_packer.sv
// tb/tb_rx_packer.sv - scoreboard bench for rx_packer
module tb_rx_packer;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         wr_en;
  logic [31:0]  wr_data;
  logic         wr_flag;
  logic         abort;
  logic         wr_ready;
  logic         read;
  logic [128:0] data_in;
  logic         timeout_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    bit           is_to;
    logic [128:0] data;
    int           cyc;
  } ev_t;

  ev_t          exp_q[$];
  logic [128:0] last_frame = '0;

  rx_packer #(.BEAT_W(32), .TIMEOUT(16)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_flag     (wr_flag),
    .abort       (abort),
    .wr_ready    (wr_ready),
    .read        (read),
    .data_in     (data_in),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [31:0] d, input logic f, input logic ab);
    wr_en   = en;
    wr_data = d;
    wr_flag = f;
    abort   = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic push_read(input logic [128:0] d, input int c);
    ev_t e;
    e.is_to = 1'b0;
    e.data  = d;
    e.cyc   = c;
    exp_q.push_back(e);
    last_frame = d;
  endtask

  task automatic push_to(input int c);
    ev_t e;
    e.is_to = 1'b1;
    e.data  = '0;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  // four beats, read expected the cycle after beat 3, then the EMIT cycle idle
  task automatic send_frame(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input logic f, input logic [128:0] exp);
    drive(1'b1, d0, 1'b0, 1'b0);
    drive(1'b1, d1, 1'b0, 1'b0);
    drive(1'b1, d2, 1'b0, 1'b0);
    push_read(exp, cyc + 1);
    drive(1'b1, d3, f, 1'b0);
    idle_cycles(1);
  endtask

  // monitor: every read / timeout_err pulse must match the head of the queue
  always @(negedge clk) begin
    ev_t e;
    if (read) begin
      if (exp_q.size() == 0) begin
        check("spurious_read", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("read_kind", {128'h0, e.is_to}, 129'h0);
        check("read_data", data_in, e.data);
        check("read_cycle", 129'(cyc), 129'(e.cyc));
        check("read_wr_ready", {128'h0, wr_ready}, 129'h0);
      end
    end
    if (timeout_err) begin
      if (exp_q.size() == 0) begin
        check("spurious_timeout", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("to_kind", {128'h0, e.is_to}, 129'h1);
        check("to_cycle", 129'(cyc), 129'(e.cyc));
      end
    end
  end

  initial begin
    int s;
    n_rst   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    wr_flag = 1'b0;
    abort   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_data_in", data_in, '0);
    check("rst_read", {128'h0, read}, 129'h0);
    check("rst_timeout_err", {128'h0, timeout_err}, 129'h0);
    check("rst_wr_ready", {128'h0, wr_ready}, 129'h1);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // key frame, first beat right after reset release
    send_frame(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 1'b0,
               129'h0_0F0E0D0C_0B0A0908_07060504_03020100);
    check("key_hold", data_in, 129'h0_0F0E0D0C_0B0A0908_07060504_03020100);

    // flag frame
    send_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
               {1'b1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF});

    // timeout: two beats, sixteen idle cycles
    drive(1'b1, 32'h11111111, 1'b0, 1'b0);
    drive(1'b1, 32'h22222222, 1'b0, 1'b0);
    push_to(cyc + 16);
    idle_cycles(16);
    check("to_data_hold", data_in, {1'b1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF});
    send_frame(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 1'b0,
               129'h0_D3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);

    // beat arriving on the would-be timeout cycle wins
    drive(1'b1, 32'h00000001, 1'b0, 1'b0);
    drive(1'b1, 32'h00000002, 1'b0, 1'b0);
    idle_cycles(15);
    drive(1'b1, 32'h00000003, 1'b0, 1'b0);
    push_read(129'h0_00000004_00000003_00000002_00000001, cyc + 1);
    drive(1'b1, 32'h00000004, 1'b0, 1'b0);
    idle_cycles(1);

    // abort together with beat 2
    drive(1'b1, 32'h55555555, 1'b0, 1'b0);
    drive(1'b1, 32'h66666666, 1'b0, 1'b0);
    drive(1'b1, 32'h77777777, 1'b1, 1'b1);
    idle_cycles(20);
    check("abort_data_hold", data_in, 129'h0_00000004_00000003_00000002_00000001);
    send_frame(32'h89ABCDEF, 32'h01234567, 32'hFEDCBA98, 32'h76543210, 1'b1,
               129'h1_76543210_FEDCBA98_01234567_89ABCDEF);

    // abort during EMIT keeps the read pulse
    drive(1'b1, 32'h10000000, 1'b0, 1'b0);
    drive(1'b1, 32'h20000000, 1'b0, 1'b0);
    drive(1'b1, 32'h30000000, 1'b0, 1'b0);
    push_read(129'h0_40000000_30000000_20000000_10000000, cyc + 1);
    drive(1'b1, 32'h40000000, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    idle_cycles(2);

    // streaming: wr_en held high, junk offered in each EMIT cycle
    s = cyc;
    for (int f = 0; f < 3; f++) begin
      logic [31:0] base;
      base = 32'h01010101 * (f + 1);
      drive(1'b1, base, 1'b0, 1'b0);
      drive(1'b1, base + 32'h1, 1'b0, 1'b0);
      drive(1'b1, base + 32'h2, 1'b0, 1'b0);
      push_read({1'b0, base + 32'h3, base + 32'h2, base + 32'h1, base}, s + 4 + 5 * f);
      drive(1'b1, base + 32'h3, 1'b0, 1'b0);
      drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    end
    idle_cycles(2);

    // reset mid-frame
    drive(1'b1, 32'h12345678, 1'b0, 1'b0);
    drive(1'b1, 32'h9ABCDEF0, 1'b0, 1'b0);
    wr_en = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    check("mrst_data_in", data_in, '0);
    check("mrst_read", {128'h0, read}, 129'h0);
    check("mrst_timeout_err", {128'h0, timeout_err}, 129'h0);
    check("mrst_wr_ready", {128'h0, wr_ready}, 129'h1);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    send_frame(32'hCAFEF00D, 32'h0000BEEF, 32'h00000000, 32'hFFFF0000, 1'b0,
               129'h0_FFFF0000_00000000_0000BEEF_CAFEF00D);
    check("mrst_low_beat", {97'h0, data_in[31:0]}, 129'hCAFEF00D);

    idle_cycles(10);
    check("queue_drained", 129'(exp_q.size()), 129'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
